// File: rtl/regfile_writeback.sv
// Architectural integer register file with per-register in-flight writer counters,
// load-use stall detection and a sticky writeback-underflow error flag.
module regfile_writeback #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned NREG  = 32,
    parameter int unsigned CNT_W = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wb_valid,
    input  logic                 wb_en,
    input  logic [4:0]           wb_rd,
    input  logic [XLEN-1:0]      wb_data,
    input  logic                 issue_valid,
    input  logic                 issue_wen,
    input  logic [4:0]           issue_rd,
    input  logic                 issue_is_load,
    input  logic [4:0]           id_rs1,
    input  logic [4:0]           id_rs2,
    input  logic                 flush,
    output logic [NREG*XLEN-1:0] regs_value,
    output logic [NREG-1:0]      busy_mask,
    output logic                 load_stall,
    output logic                 issue_full,
    output logic                 wb_underflow
);

    localparam logic [CNT_W-1:0] CntMax = '1;

    logic [XLEN-1:0]  r_regs    [NREG];
    logic [CNT_W-1:0] r_cnt     [NREG];
    logic [CNT_W-1:0] w_cnt_d   [NREG];
    logic [NREG-1:0]  r_lflag;
    logic [NREG-1:0]  w_lflag_d;
    logic             r_underflow;
    logic             w_underflow_d;

    logic             w_issue_ev;
    logic             w_wb_ev;
    logic [NREG-1:0]  w_inc;
    logic [NREG-1:0]  w_dec;

    assign w_issue_ev = issue_valid && issue_wen && (issue_rd != 5'd0);
    assign w_wb_ev    = wb_valid && wb_en && (wb_rd != 5'd0);

    always_comb begin
        w_inc = '0;
        w_dec = '0;
        for (int i = 1; i < NREG; i++) begin
            w_inc[i] = w_issue_ev && (issue_rd == 5'(i));
            w_dec[i] = w_wb_ev && (wb_rd == 5'(i));
        end
    end

    // Counter and load-flag next state; flush wins over any same-cycle issue or writeback.
    always_comb begin
        w_underflow_d = r_underflow;
        for (int i = 0; i < NREG; i++) begin
            w_cnt_d[i]   = r_cnt[i];
            w_lflag_d[i] = r_lflag[i];
            if (i == 0 || flush) begin
                w_cnt_d[i]   = '0;
                w_lflag_d[i] = 1'b0;
            end else begin
                if (w_inc[i] && !w_dec[i]) begin
                    if (r_cnt[i] != CntMax) begin
                        w_cnt_d[i] = r_cnt[i] + 1'b1;
                    end
                end else if (w_dec[i] && !w_inc[i]) begin
                    if (r_cnt[i] == '0) begin
                        w_underflow_d = 1'b1;
                    end else begin
                        w_cnt_d[i] = r_cnt[i] - 1'b1;
                    end
                end
                if (w_cnt_d[i] == '0) begin
                    w_lflag_d[i] = 1'b0;
                end else if (w_inc[i]) begin
                    w_lflag_d[i] = issue_is_load;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                r_cnt[i] <= '0;
            end
            r_lflag     <= '0;
            r_underflow <= 1'b0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                r_cnt[i] <= w_cnt_d[i];
            end
            r_lflag     <= w_lflag_d;
            r_underflow <= w_underflow_d;
        end
    end

    // Writeback still lands during flush: WB is older than the squash point.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            r_regs[0] <= '0;
            for (int i = 1; i < NREG; i++) begin
                if (w_dec[i]) begin
                    r_regs[i] <= wb_data;
                end
            end
        end
    end

    always_comb begin
        regs_value = '0;
        busy_mask  = '0;
        for (int i = 0; i < NREG; i++) begin
            regs_value[i*XLEN +: XLEN] = r_regs[i];
            busy_mask[i]               = (i != 0) && (r_cnt[i] != '0);
        end
    end

    assign load_stall = ((id_rs1 != 5'd0) && (r_cnt[id_rs1] != '0) && r_lflag[id_rs1]) ||
                        ((id_rs2 != 5'd0) && (r_cnt[id_rs2] != '0) && r_lflag[id_rs2]);

    assign issue_full   = issue_wen && (issue_rd != 5'd0) && (r_cnt[issue_rd] == CntMax);
    assign wb_underflow = r_underflow;

endmodule

// File: doc/regfile_writeback.md
Name: regfile_writeback

Overview:
- Architectural register file and write-side companion to the ID-stage decoder. It owns the 32 integer registers and accepts one writeback commit per cycle from WB.
- It tracks in-flight writers per destination register, using pending counters set at issue and cleared at writeback.
- It presents the full register array to ID, and raises a load-use stall when an issuing instruction's sources depend on an unretired load.

Parameters:
XLEN, 64, register width in bits
NREG, 32, number of architectural registers (index 0 hardwired zero)
CNT_W, 2, width of per-register pending counter (max in-flight writers = 2^CNT_W-1)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
wb_valid  input  1  writeback slot holds a retiring instruction
wb_en  input  1  retiring instruction writes rd
wb_rd  input  5  writeback destination index
wb_data  input  XLEN  writeback value
issue_valid  input  1  ID hands an instruction to EX this cycle (already qualified by stall)
issue_wen  input  1  issuing instruction writes rd
issue_rd  input  5  issuing destination index
issue_is_load  input  1  issuing instruction is a load
id_rs1  input  5  source 1 index of instruction currently in ID
id_rs2  input  5  source 2 index of instruction currently in ID
flush  input  1  squash all younger-than-WB in-flight writers
regs_value  output  NREG*XLEN  packed register array, entry i at [i*XLEN +: XLEN]
busy_mask  output  NREG  bit i = pending counter i nonzero
load_stall  output  1  ID must hold: a source is pending from a load
issue_full  output  1  issue_rd counter at max; ID must hold
wb_underflow  output  1  sticky error: writeback to reg with zero pending count

Behaviour:
- Reset (async, rst_n=0): all registers 0, all counters 0, all load flags 0, wb_underflow 0. All outputs reflect these values immediately.
- Register write: on a rising edge with wb_valid&&wb_en&&wb_rd!=0, regs[wb_rd] <= wb_data. The value is visible on regs_value the next cycle.
  - No internal bypass; same-cycle forwarding is ID's job.
- Index 0: never written, never counted, never flagged. Reads always 0.
- Effective events: issue_ev = issue_valid&&issue_wen&&issue_rd!=0; wb_ev = wb_valid&&wb_en&&wb_rd!=0.
- Counter update, per register r:
  - +1 if issue_ev&&issue_rd==r.
  - -1 if wb_ev&&wb_rd==r.
  - Both events to the same register in the same cycle leave the counter unchanged.
- Underflow: a decrement with counter==0 leaves the counter at 0, still writes the register, and sets wb_underflow. wb_underflow clears only on reset.
- Overflow guard: issue_full = issue_wen && issue_rd!=0 && cnt[issue_rd]==max, combinational.
  - If issue_ev occurs while the counter is at max with no same-cycle wb to that register, the counter holds at max (ID protocol violation; not flagged).
- Load flag, per register:
  - Set on issue_ev of a load to r.
  - Cleared on issue_ev of a non-load to r, since the youngest writer is not a load.
  - Cleared when the counter transitions to 0.
  - A simultaneous wb to r that does not reach 0 leaves the issue rule in force.
- load_stall (combinational) = (id_rs1!=0 && cnt[id_rs1]!=0 && lflag[id_rs1]) || (id_rs2!=0 && cnt[id_rs2]!=0 && lflag[id_rs2]).
- busy_mask[0] always 0.
- Flush: on the clock edge with flush=1, all counters and load flags are cleared.
  - Same-cycle issue is discarded.
  - A same-cycle writeback still writes its register value, because WB is older than the flush point. It does not raise underflow.
  - Writebacks of squashed instructions are suppressed upstream.
- Reset mid-operation: asserting rst_n=0 aborts everything asynchronously. Any same-edge writeback is lost.

Test Plan:
- Reset with rst_n=0, then release → regs_value all 0, busy_mask=0, load_stall=0, wb_underflow=0.
- Issue non-load rd=5; 3 cycles later wb rd=5 data=0x1234 → busy_mask[5]=1 until the wb edge. regs[5]=0x1234 the cycle after. Counter returns to 0.
- Issue load rd=7, then hold id_rs1=7 → load_stall=1. Assert wb rd=7 → load_stall=0 the next cycle. Repeat with id_rs2=7 and get the same result.
- Issue rd=3 three times (CNT_W=2) → issue_full=1 with issue_rd=3. Same-cycle issue+wb on rd=3 keeps counter=3.
  - After three wbs, counter=0. A fourth wb sets wb_underflow=1 and still writes the value.
- Write x0: wb rd=0 data=0xFFFF, and issue load rd=0 → regs[0]=0, busy_mask[0]=0. id_rs1=0 gives no stall.
- Flush: pending loads on rd=2 and rd=9, then flush together with wb rd=4 data=0xAB → busy_mask=0 and load_stall=0 next cycle. regs[4]=0xAB. No underflow on later spurious-free operation.
